// File: rtl/fb_rect_writer_if.sv
// Command and memory-write bundle for the rectangle fill engine.
// The master side issues commands and arbitrates the write port.
// The slave side is the fill engine itself.
interface fb_rect_writer_if #(
    parameter int ADDR_W = 16
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic [7:0]        cmd_x;
    logic [7:0]        cmd_y;
    logic [7:0]        cmd_w;
    logic [7:0]        cmd_h;
    logic [7:0]        cmd_color;
    logic              abort;
    logic              mem_grant;
    logic              mem_wren;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_wdata;
    logic              busy;
    logic              done;

    modport master (
        output cmd_valid, cmd_x, cmd_y, cmd_w, cmd_h, cmd_color, abort, mem_grant,
        input  cmd_ready, mem_wren, mem_addr, mem_wdata, busy, done
    );

    modport slave (
        input  cmd_valid, cmd_x, cmd_y, cmd_w, cmd_h, cmd_color, abort, mem_grant,
        output cmd_ready, mem_wren, mem_addr, mem_wdata, busy, done
    );
endinterface

// File: rtl/fb_rect_writer.sv
// Rectangle fill engine: clips a command rectangle to the framebuffer and
// writes one colour byte per granted cycle, row-major, into the shared
// memory write port. The write port is arbitrated externally via mem_grant.
module fb_rect_writer #(
    parameter int                FB_WIDTH  = 128,
    parameter int                FB_HEIGHT = 128,
    parameter int                ADDR_W    = 16,
    parameter logic [ADDR_W-1:0] BASE_ADDR = 16'h0000
) (
    input  logic              clk,
    input  logic              rst,
    fb_rect_writer_if.slave   bus
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CLIP,
        S_WRITE,
        S_DONE
    } state_t;

    localparam logic [8:0]        FB_W9 = 9'(FB_WIDTH);
    localparam logic [8:0]        FB_H9 = 9'(FB_HEIGHT);
    localparam logic [ADDR_W-1:0] FB_WA = ADDR_W'(FB_WIDTH);

    state_t            r_state;
    logic [7:0]        r_x;
    logic [7:0]        r_y;
    logic [7:0]        r_w;
    logic [7:0]        r_h;
    logic [7:0]        r_color;
    logic [8:0]        r_xe;
    logic [8:0]        r_ye;
    logic [8:0]        r_col;
    logic [8:0]        r_row;
    logic [ADDR_W-1:0] r_rowBase;
    logic [ADDR_W-1:0] r_addr;
    logic [7:0]        r_wdata;
    logic              r_wren;
    logic              r_done;

    logic              w_accept;
    logic [8:0]        w_xSum;
    logic [8:0]        w_ySum;
    logic [8:0]        w_xe;
    logic [8:0]        w_ye;
    logic              w_empty;
    logic [ADDR_W-1:0] w_clipBase;
    logic [ADDR_W-1:0] w_nextRowBase;
    logic [8:0]        w_colNext;
    logic              w_rowEnd;
    logic              w_lastPix;
    logic              w_granted;

    // Clip arithmetic is done in 9 bits so x+w never wraps past 255.
    assign w_accept      = bus.cmd_valid && (r_state == S_IDLE);
    assign w_xSum        = {1'b0, r_x} + {1'b0, r_w};
    assign w_ySum        = {1'b0, r_y} + {1'b0, r_h};
    assign w_xe          = (w_xSum > FB_W9) ? FB_W9 : w_xSum;
    assign w_ye          = (w_ySum > FB_H9) ? FB_H9 : w_ySum;
    assign w_empty       = (r_w == 8'd0) || (r_h == 8'd0) ||
                           ({1'b0, r_x} >= FB_W9) || ({1'b0, r_y} >= FB_H9);
    assign w_clipBase    = BASE_ADDR + ADDR_W'(r_y) * FB_WA;
    assign w_nextRowBase = r_rowBase + FB_WA;
    assign w_colNext     = r_col + 9'd1;
    assign w_rowEnd      = (w_colNext == r_xe);
    assign w_lastPix     = w_rowEnd && ((r_row + 9'd1) == r_ye);
    assign w_granted     = r_wren && bus.mem_grant;

    assign bus.cmd_ready = (r_state == S_IDLE);
    assign bus.busy      = (r_state != S_IDLE);
    assign bus.mem_wren  = r_wren;
    assign bus.mem_addr  = r_addr;
    assign bus.mem_wdata = r_wdata;
    assign bus.done      = r_done;

    // Fill sequencer: latches the command, clips it, then walks the pixels,
    // advancing only on granted writes; abort drops straight back to idle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= S_IDLE;
            r_x       <= 8'd0;
            r_y       <= 8'd0;
            r_w       <= 8'd0;
            r_h       <= 8'd0;
            r_color   <= 8'd0;
            r_xe      <= 9'd0;
            r_ye      <= 9'd0;
            r_col     <= 9'd0;
            r_row     <= 9'd0;
            r_rowBase <= BASE_ADDR;
            r_addr    <= BASE_ADDR;
            r_wdata   <= 8'd0;
            r_wren    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_x     <= bus.cmd_x;
                        r_y     <= bus.cmd_y;
                        r_w     <= bus.cmd_w;
                        r_h     <= bus.cmd_h;
                        r_color <= bus.cmd_color;
                        r_state <= S_CLIP;
                    end
                end
                S_CLIP: begin
                    if (bus.abort) begin
                        r_state <= S_IDLE;
                    end else if (w_empty) begin
                        r_state <= S_DONE;
                        r_done  <= 1'b1;
                    end else begin
                        r_xe      <= w_xe;
                        r_ye      <= w_ye;
                        r_col     <= {1'b0, r_x};
                        r_row     <= {1'b0, r_y};
                        r_rowBase <= w_clipBase;
                        r_addr    <= w_clipBase + ADDR_W'(r_x);
                        r_wdata   <= r_color;
                        r_wren    <= 1'b1;
                        r_state   <= S_WRITE;
                    end
                end
                S_WRITE: begin
                    if (bus.abort) begin
                        r_wren  <= 1'b0;
                        r_state <= S_IDLE;
                    end else if (w_granted) begin
                        if (w_lastPix) begin
                            r_wren  <= 1'b0;
                            r_done  <= 1'b1;
                            r_state <= S_DONE;
                        end else if (w_rowEnd) begin
                            r_col     <= {1'b0, r_x};
                            r_row     <= r_row + 9'd1;
                            r_rowBase <= w_nextRowBase;
                            r_addr    <= w_nextRowBase + ADDR_W'(r_x);
                        end else begin
                            r_col  <= w_colNext;
                            r_addr <= r_rowBase + ADDR_W'(w_colNext);
                        end
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_wren  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fb_rect_writer.sv
// Self-checking bench for fb_rect_writer: a reference model expands each
// accepted rectangle into its expected byte writes, and an independent
// monitor pops and compares them as the engine performs granted writes.
module tb_fb_rect_writer;

    localparam int FB_W   = 128;
    localparam int FB_H   = 128;
    localparam int ADDR_W = 16;
    localparam int BASE   = 0;

    logic clk;
    logic rst;

    fb_rect_writer_if #(.ADDR_W(ADDR_W)) bus();

    fb_rect_writer #(
        .FB_WIDTH (FB_W),
        .FB_HEIGHT(FB_H),
        .ADDR_W   (ADDR_W),
        .BASE_ADDR(16'h0000)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int checks = 0;
    int errors = 0;
    int cycle  = 0;

    logic [ADDR_W+7:0] expQ[$];
    int expDone      = 0;
    int lastExpCount = 0;

    int acceptCycle  = 0;
    int firstWrCycle = -1;
    int wrSince      = 0;
    int stallSince   = 0;
    int doneCount    = 0;
    int doneCycle    = -1;

    int grantRandom  = 0;
    int stallFrom    = 0;
    int stallTo      = 0;

    logic              prevStall = 1'b0;
    logic [ADDR_W-1:0] prevAddr  = '0;
    logic [7:0]        prevData  = '0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cycle);
        end
    endtask

    task automatic failNow(input string name, input logic [63:0] act);
        checks++;
        errors++;
        $display("[TB] FAIL %s: got 0x%0h, expected nothing (cycle %0d)", name, act, cycle);
    endtask

    // Reference model: every on-screen pixel of the rectangle, row-major.
    task automatic modelCmd(input int x, input int y, input int w, input int h,
                            input int c, input int maxWr);
        int xe, ye, n;
        xe = (x + w > FB_W) ? FB_W : x + w;
        ye = (y + h > FB_H) ? FB_H : y + h;
        n  = 0;
        for (int r = y; r < ye; r++) begin
            for (int col = x; col < xe; col++) begin
                if (maxWr < 0 || n < maxWr) begin
                    expQ.push_back({16'((BASE + r * FB_W + col) & 16'hFFFF), 8'(c)});
                    n++;
                end
            end
        end
        lastExpCount = n;
    endtask

    // Grant driver: either random, or high except inside a stall window.
    initial begin
        bus.mem_grant = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (grantRandom != 0)
                bus.mem_grant = ($urandom_range(0, 3) != 0);
            else
                bus.mem_grant = !(cycle >= stallFrom && cycle < stallTo);
        end
    end

    // Monitor: scoreboard pops on every granted write, checks stall holds and done.
    initial begin
        logic [ADDR_W+7:0] e;
        forever begin
            @(negedge clk);
            if (!rst) begin
                prevStall = 1'b0;
            end else begin
                if (prevStall)
                    checkOutput("stall_hold", {bus.mem_wren, bus.mem_addr, bus.mem_wdata},
                                {1'b1, prevAddr, prevData});
                if (bus.mem_wren && bus.mem_grant) begin
                    if (firstWrCycle < 0) firstWrCycle = cycle;
                    wrSince++;
                    if (expQ.size() == 0) begin
                        failNow("unexpected_write", {bus.mem_addr, bus.mem_wdata});
                    end else begin
                        e = expQ.pop_front();
                        checkOutput("write_addr_data", {bus.mem_addr, bus.mem_wdata}, e);
                    end
                end
                prevStall = bus.mem_wren && !bus.mem_grant;
                prevAddr  = bus.mem_addr;
                prevData  = bus.mem_wdata;
                if (prevStall) stallSince++;
                if (bus.done) begin
                    doneCount++;
                    doneCycle = cycle;
                    if (expDone == 0) begin
                        failNow("unexpected_done", 1);
                    end else begin
                        expDone--;
                        checkOutput("done_after_all_writes", expQ.size(), 0);
                    end
                end
            end
        end
    end

    // Issue one command once the engine is ready; fields are scrambled after acceptance.
    task automatic applyStimulus(input int x, input int y, input int w, input int h,
                                 input int c, input int maxWr, input int wantDone);
        int n;
        n = 0;
        @(negedge clk);
        while (!bus.cmd_ready && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (!bus.cmd_ready) failNow("ready_timeout", n);
        modelCmd(x, y, w, h, c, maxWr);
        if (wantDone != 0) expDone++;
        bus.cmd_valid = 1'b1;
        bus.cmd_x     = 8'(x);
        bus.cmd_y     = 8'(y);
        bus.cmd_w     = 8'(w);
        bus.cmd_h     = 8'(h);
        bus.cmd_color = 8'(c);
        @(posedge clk);
        #1;
        acceptCycle  = cycle;
        firstWrCycle = -1;
        wrSince      = 0;
        stallSince   = 0;
        bus.cmd_valid = 1'b0;
        bus.cmd_x     = 8'($urandom);
        bus.cmd_y     = 8'($urandom);
        bus.cmd_w     = 8'($urandom);
        bus.cmd_h     = 8'($urandom);
        bus.cmd_color = 8'($urandom);
    endtask

    task automatic waitForDone(input int bound);
        int start, n;
        start = doneCount;
        n = 0;
        while (doneCount == start && n < bound) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (doneCount == start) failNow("done_timeout", n);
    endtask

    initial begin
        int startDone;
        rst           = 1'b0;
        bus.cmd_valid = 1'b0;
        bus.cmd_x     = 8'd0;
        bus.cmd_y     = 8'd0;
        bus.cmd_w     = 8'd0;
        bus.cmd_h     = 8'd0;
        bus.cmd_color = 8'd0;
        bus.abort     = 1'b0;

        // Reset values
        #23;
        checkOutput("rst_cmd_ready", bus.cmd_ready, 1);
        checkOutput("rst_mem_wren", bus.mem_wren, 0);
        checkOutput("rst_mem_addr", bus.mem_addr, 0);
        checkOutput("rst_mem_wdata", bus.mem_wdata, 0);
        checkOutput("rst_busy", bus.busy, 0);
        checkOutput("rst_done", bus.done, 0);
        @(negedge clk);
        rst = 1'b1;

        // Basic 3x2 fill with continuous grant
        applyStimulus(2, 1, 3, 2, 8'hA5, -1, 1);
        waitForDone(50);
        checkOutput("t1_first_write_latency", firstWrCycle, acceptCycle + 1);
        checkOutput("t1_done_latency", doneCycle, acceptCycle + 7);
        @(negedge clk);
        checkOutput("t1_busy_after", bus.busy, 0);
        checkOutput("t1_ready_after", bus.cmd_ready, 1);

        // Clipped at the bottom-right corner
        applyStimulus(126, 127, 10, 10, 8'h3C, -1, 1);
        waitForDone(50);
        checkOutput("t2_write_count", wrSince, 2);
        checkOutput("t2_done_latency", doneCycle, acceptCycle + 3);

        // Empty rectangles
        applyStimulus(5, 5, 0, 5, 8'h11, -1, 1);
        waitForDone(20);
        checkOutput("t3a_no_write", firstWrCycle, -1);
        checkOutput("t3a_done_latency", doneCycle, acceptCycle + 1);
        applyStimulus(200, 5, 4, 4, 8'h22, -1, 1);
        waitForDone(20);
        checkOutput("t3b_no_write", firstWrCycle, -1);
        checkOutput("t3b_done_latency", doneCycle, acceptCycle + 1);

        // Three stalled cycles on the second pixel
        applyStimulus(2, 1, 3, 2, 8'hA5, -1, 1);
        stallFrom = acceptCycle + 2;
        stallTo   = acceptCycle + 5;
        waitForDone(60);
        checkOutput("t4_stall_cycles", stallSince, 3);
        checkOutput("t4_write_count", wrSince, 6);
        checkOutput("t4_done_latency", doneCycle, acceptCycle + 10);
        stallFrom = 0;
        stallTo   = 0;

        // Abort in the second write cycle: two writes, no done
        startDone = doneCount;
        applyStimulus(10, 5, 4, 1, 8'h5A, 2, 0);
        @(posedge clk);
        @(posedge clk);
        #1 bus.abort = 1'b1;
        @(posedge clk);
        #1 bus.abort = 1'b0;
        @(negedge clk);
        checkOutput("t5_ready_after_abort", bus.cmd_ready, 1);
        checkOutput("t5_wren_after_abort", bus.mem_wren, 0);
        repeat (4) @(negedge clk);
        checkOutput("t5_write_count", wrSince, 2);
        checkOutput("t5_no_done", doneCount, startDone);
        applyStimulus(0, 0, 2, 1, 8'h99, -1, 1);
        waitForDone(30);
        checkOutput("t5_next_done_latency", doneCycle, acceptCycle + 3);

        // Asynchronous reset in the middle of a fill
        applyStimulus(0, 10, 30, 3, 8'h77, -1, 1);
        repeat (3) @(posedge clk);
        #2;
        checkOutput("t6_writing_before_reset", bus.mem_wren, 1);
        startDone = doneCount;
        rst = 1'b0;
        #1;
        checkOutput("t6_wren_async_clear", bus.mem_wren, 0);
        checkOutput("t6_busy_async_clear", bus.busy, 0);
        expQ.delete();
        expDone = 0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1;
        checkOutput("t6_ready_after_reset", bus.cmd_ready, 1);
        repeat (5) @(negedge clk);
        checkOutput("t6_no_done", doneCount, startDone);

        // Randomized commands with random grant
        grantRandom = 1;
        for (int i = 0; i < 40; i++) begin
            int rx, ry, rw, rh;
            rx = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 255) : $urandom_range(100, 135);
            ry = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 255) : $urandom_range(0, 135);
            rw = $urandom_range(0, 20);
            rh = $urandom_range(0, 20);
            applyStimulus(rx, ry, rw, rh, $urandom_range(0, 255), -1, 1);
            waitForDone(3000);
            checkOutput("rand_write_count", wrSince, lastExpCount);
            checkOutput("rand_done_latency", doneCycle, acceptCycle + 1 + wrSince + stallSince);
        end
        grantRandom = 0;
        repeat (3) @(negedge clk);
        checkOutput("final_queue_empty", expQ.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
